sensor_cond: RTL and testbench

//  Conditions the four raw 12-bit A2D readings (batt, curr, brake, torque) produced by the
//  A2D interface into filtered, debounced values and flags for the downstream motor/PID logic.

---
 rtl/ebike_pkg.sv | 15 +
 rtl/sample_timer.sv | 31 +++
 rtl/sensor_cond.sv | 154 +++++++++++++++
 tb/tb_sensor_cond.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/ebike_pkg.sv
// Shared types for the e-bike sensor/motor datapath.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ebike_pkg;

    // Conditioner lifecycle: INIT waits for the first sample tick, RUN filters.
    typedef enum logic {INIT, RUN} cond_state_t;

    // Raw 12-bit A2D reading.
    typedef logic [11:0] adc_t;

    // Torque accumulator holds 32x a 12-bit sample; 17 bits covers 32*4095.
    localparam int ACCUM_W = 17;

endpackage

// File: rtl/sample_timer.sv
// Free-running period counter producing a one-cycle sample tick.
// Latency: tick is high during the cycle where the count equals PERIOD-1.
// Backpressure: none; the timer never stalls.
// Ports: clk (rising edge), rst (sync, active-high), tick (1-cycle pulse every PERIOD clocks).
module sample_timer #(
    parameter int PERIOD = 16384
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int W = (PERIOD > 1) ? $clog2(PERIOD) : 1;

    logic [W-1:0] tmr_q;
    logic [W-1:0] tmr_d;

    always_comb begin
        tick  = (tmr_q == W'(PERIOD - 1));
        tmr_d = tick ? '0 : tmr_q + W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tmr_q <= '0;
        end else begin
            tmr_q <= tmr_d;
        end
    end

endmodule

// File: rtl/sensor_cond.sv
// Conditions raw batt/curr/brake/torque readings into filtered values and flags.
// Latency: outputs update one clock after each sample tick and hold between ticks.
// Backpressure: none; inputs are sampled only on the tick, vld is a level.
// Ports: clk, rst (sync, active-high); batt/curr/brake/torque raw 12-bit inputs;
//        avg_torque, avg_curr (12-bit); batt_low, brake_on, not_pedaling flags; vld.
module sensor_cond
    import ebike_pkg::*;
#(
    parameter int   SMPL_PER  = 16384,
    parameter adc_t BATT_LOW  = 12'hA90,
    parameter adc_t BATT_HYST = 12'h040,
    parameter adc_t BRAKE_THR = 12'h800,
    parameter adc_t PED_THR   = 12'h080,
    parameter int   PED_TICKS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] batt,
    input  logic [11:0] curr,
    input  logic [11:0] brake,
    input  logic [11:0] torque,
    output logic [11:0] avg_torque,
    output logic [11:0] avg_curr,
    output logic        batt_low,
    output logic        brake_on,
    output logic        not_pedaling,
    output logic        vld
);

    localparam int CNT_W = $clog2(PED_TICKS + 1);

    logic tick;

    sample_timer #(.PERIOD(SMPL_PER)) u_timer (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    cond_state_t          state_q,        state_d;
    logic [ACCUM_W-1:0]   accum_q,        accum_d;
    adc_t                 curr_buf_q [4];
    adc_t                 curr_buf_d [4];
    logic                 batt_low_q,     batt_low_d;
    logic                 brake_on_q,     brake_on_d;
    logic [CNT_W-1:0]     idle_cnt_q,     idle_cnt_d;
    logic                 not_ped_q,      not_ped_d;
    logic                 vld_q,          vld_d;

    logic [13:0]          curr_sum;
    logic [12:0]          batt_ext;
    logic                 batt_set;
    logic                 batt_clr;
    logic                 brake_hit;

    // Thresholds compared in 13 bits so BATT_LOW+BATT_HYST cannot wrap.
    always_comb begin
        batt_ext  = {1'b0, batt};
        batt_set  = batt_ext < {1'b0, BATT_LOW};
        batt_clr  = batt_ext > ({1'b0, BATT_LOW} + {1'b0, BATT_HYST});
        brake_hit = brake > BRAKE_THR;
    end

    always_comb begin
        state_d    = state_q;
        accum_d    = accum_q;
        curr_buf_d = curr_buf_q;
        batt_low_d = batt_low_q;
        brake_on_d = brake_on_q;
        idle_cnt_d = idle_cnt_q;
        not_ped_d  = not_ped_q;
        vld_d      = vld_q;

        if (tick) begin
            // Hysteresis: set below the low mark, clear above low+hyst, else hold.
            if (batt_set) begin
                batt_low_d = 1'b1;
            end else if (batt_clr) begin
                batt_low_d = 1'b0;
            end
            brake_on_d = brake_hit;
            vld_d      = 1'b1;

            case (state_q)
                INIT: begin
                    // Seed the filters so they start at the first reading
                    // instead of ramping up from zero.
                    accum_d = {torque, 5'b0};
                    for (int i = 0; i < 4; i++) begin
                        curr_buf_d[i] = curr;
                    end
                    idle_cnt_d = (torque < PED_THR) ? CNT_W'(1) : '0;
                    state_d    = RUN;
                end
                RUN: begin
                    // Exponential average with weight 1/32.
                    accum_d = accum_q - (accum_q >> 5) + ACCUM_W'(torque);
                    curr_buf_d[0] = curr;
                    for (int i = 1; i < 4; i++) begin
                        curr_buf_d[i] = curr_buf_q[i-1];
                    end
                    // Idle test uses the average as it stood before this tick.
                    if (avg_torque < PED_THR) begin
                        if (idle_cnt_q != CNT_W'(PED_TICKS)) begin
                            idle_cnt_d = idle_cnt_q + CNT_W'(1);
                        end
                    end else begin
                        idle_cnt_d = '0;
                    end
                end
                default: state_d = INIT;
            endcase

            not_ped_d = (idle_cnt_d == CNT_W'(PED_TICKS));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= INIT;
            accum_q    <= '0;
            for (int i = 0; i < 4; i++) begin
                curr_buf_q[i] <= '0;
            end
            batt_low_q <= 1'b0;
            brake_on_q <= 1'b0;
            idle_cnt_q <= '0;
            not_ped_q  <= 1'b0;
            vld_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            accum_q    <= accum_d;
            curr_buf_q <= curr_buf_d;
            batt_low_q <= batt_low_d;
            brake_on_q <= brake_on_d;
            idle_cnt_q <= idle_cnt_d;
            not_ped_q  <= not_ped_d;
            vld_q      <= vld_d;
        end
    end

    always_comb begin
        curr_sum = {2'b0, curr_buf_q[0]} + {2'b0, curr_buf_q[1]}
                 + {2'b0, curr_buf_q[2]} + {2'b0, curr_buf_q[3]};
    end

    assign avg_torque   = accum_q[16:5];
    assign avg_curr     = 12'(curr_sum >> 2);
    assign batt_low     = batt_low_q;
    assign brake_on     = brake_on_q;
    assign not_pedaling = not_ped_q;
    assign vld          = vld_q;

endmodule

// File: tb/tb_sensor_cond.sv
module tb_sensor_cond;

    localparam int PER = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] batt, curr, brake, torque;
    logic [11:0] avg_torque, avg_curr;
    logic        batt_low, brake_on, not_pedaling, vld;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sensor_cond #(.SMPL_PER(PER)) dut (
        .clk          (clk),
        .rst          (rst),
        .batt         (batt),
        .curr         (curr),
        .brake        (brake),
        .torque       (torque),
        .avg_torque   (avg_torque),
        .avg_curr     (avg_curr),
        .batt_low     (batt_low),
        .brake_on     (brake_on),
        .not_pedaling (not_pedaling),
        .vld          (vld)
    );

    // One record per sample tick: inputs driven before it, outputs expected after it.
    typedef struct {
        logic [11:0] batt;
        logic [11:0] curr;
        logic [11:0] brake;
        logic [11:0] torque;
        bit          chk_avg;
        logic [11:0] exp_at;
        logic [11:0] exp_ac;
        bit          chk_flags;
        logic        exp_bl;
        logic        exp_bo;
        bit          chk_np;
        logic        exp_np;
    } vec_t;

    vec_t vecs [9];
    vec_t sb_q [$];

    task automatic check(input string name, input logic [16:0] act, input logic [16:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive a record, let one full sample period elapse, then compare.
    task automatic run_tick(input vec_t v);
        vec_t e;
        batt   = v.batt;
        curr   = v.curr;
        brake  = v.brake;
        torque = v.torque;
        sb_q.push_back(v);
        repeat (PER) @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check("scoreboard_empty", 17'd0, 17'd1);
        end else begin
            e = sb_q.pop_front();
            check("vld", 17'(vld), 17'd1);
            if (e.chk_avg) begin
                check("avg_torque", 17'(avg_torque), 17'(e.exp_at));
                check("avg_curr", 17'(avg_curr), 17'(e.exp_ac));
            end
            if (e.chk_flags) begin
                check("batt_low", 17'(batt_low), 17'(e.exp_bl));
                check("brake_on", 17'(brake_on), 17'(e.exp_bo));
            end
            if (e.chk_np) begin
                check("not_pedaling", 17'(not_pedaling), 17'(e.exp_np));
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_avg_torque"}, 17'(avg_torque), 17'd0);
        check({tag, "_avg_curr"}, 17'(avg_curr), 17'd0);
        check({tag, "_batt_low"}, 17'(batt_low), 17'd0);
        check({tag, "_brake_on"}, 17'(brake_on), 17'd0);
        check({tag, "_not_pedaling"}, 17'(not_pedaling), 17'd0);
        check({tag, "_vld"}, 17'(vld), 17'd0);
    endtask

    function automatic vec_t mk(input logic [11:0] b, input logic [11:0] c,
                                input logic [11:0] br, input logic [11:0] t,
                                input bit ca, input logic [11:0] at, input logic [11:0] ac,
                                input bit cf, input logic bl, input logic bo,
                                input bit cn, input logic np);
        vec_t v;
        v.batt = b;  v.curr = c;  v.brake = br;  v.torque = t;
        v.chk_avg = ca;  v.exp_at = at;  v.exp_ac = ac;
        v.chk_flags = cf; v.exp_bl = bl; v.exp_bo = bo;
        v.chk_np = cn;   v.exp_np = np;
        return v;
    endfunction

    initial begin
        // Seed, constant hold, torque step to FFF, current ramp, hysteresis and brake edges.
        //            batt     curr     brake    torque   avg  at       ac       flg bl    bo    np  np
        vecs[0] = mk(12'hB00, 12'h000, 12'h000, 12'h800, 1, 12'h800, 12'h000, 1, 1'b0, 1'b0, 1, 1'b0);
        vecs[1] = mk(12'hA8F, 12'h100, 12'h801, 12'h800, 1, 12'h800, 12'h040, 1, 1'b1, 1'b1, 1, 1'b0);
        vecs[2] = mk(12'hAC0, 12'h200, 12'h800, 12'hFFF, 1, 12'h83F, 12'h0C0, 1, 1'b1, 1'b0, 1, 1'b0);
        vecs[3] = mk(12'hAD1, 12'h300, 12'hFFF, 12'hFFF, 1, 12'h87D, 12'h180, 1, 1'b0, 1'b1, 1, 1'b0);
        vecs[4] = mk(12'hA90, 12'h400, 12'h000, 12'hFFF, 1, 12'h8BA, 12'h280, 1, 1'b0, 1'b0, 1, 1'b0);
        vecs[5] = mk(12'hAD0, 12'h400, 12'h000, 12'hFFF, 0, 12'h000, 12'h000, 1, 1'b0, 1'b0, 1, 1'b0);
        vecs[6] = mk(12'hA8F, 12'h400, 12'h000, 12'hFFF, 0, 12'h000, 12'h000, 1, 1'b1, 1'b0, 1, 1'b0);
        vecs[7] = mk(12'hAD0, 12'h400, 12'h000, 12'hFFF, 0, 12'h000, 12'h000, 1, 1'b1, 1'b0, 1, 1'b0);
        vecs[8] = mk(12'hAD1, 12'h400, 12'h000, 12'hFFF, 0, 12'h000, 12'h000, 1, 1'b0, 1'b0, 1, 1'b0);

        // Reset held three clocks with all inputs high.
        rst = 1'b1;
        batt = 12'hFFF; curr = 12'hFFF; brake = 12'hFFF; torque = 12'hFFF;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;

        // First tick is 16 edges after the last reset edge; vld must still be low one edge earlier.
        batt = vecs[0].batt; curr = vecs[0].curr; brake = vecs[0].brake; torque = vecs[0].torque;
        repeat (PER - 1) @(posedge clk);
        #1;
        check("vld_before_tick", 17'(vld), 17'd0);
        check("avg_torque_before_tick", 17'(avg_torque), 17'd0);
        @(posedge clk);
        #1;
        check("vld_first_tick", 17'(vld), 17'd1);
        check("seed_avg_torque", 17'(avg_torque), 17'h800);
        for (int i = 1; i < 9; i++) begin
            run_tick(vecs[i]);
        end

        // Pedal idle: restart clean, torque zero from the seed onward.
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            run_tick(mk(12'hB00, 12'h000, 12'h000, 12'h000, 1, 12'h000, 12'h000,
                        1, 1'b0, 1'b0, (i == 6 || i == 10), (i == 10)));
        end
        // Pedalling resumes; average climbs past the threshold after two ticks.
        for (int i = 1; i <= 4; i++) begin
            run_tick(mk(12'hB00, 12'h000, 12'h000, 12'hFFF, 0, 12'h000, 12'h000,
                        1, 1'b0, 1'b0, (i == 4), 1'b0));
        end

        // Reset asserted on a tick edge must win over the tick.
        batt = 12'hA00; brake = 12'hFFF; torque = 12'h100; curr = 12'h100;
        repeat (PER - 1) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_all_zero("tick_reset");
        repeat (PER - 1) @(posedge clk);
        #1;
        check("vld_after_tick_reset", 17'(vld), 17'd0);
        @(posedge clk);
        #1;
        check("vld_reseed", 17'(vld), 17'd1);
        check("reseed_avg_torque", 17'(avg_torque), 17'h100);
        check("reseed_avg_curr", 17'(avg_curr), 17'h100);
        check("reseed_batt_low", 17'(batt_low), 17'd1);
        check("reseed_brake_on", 17'(brake_on), 17'd1);

        if (sb_q.size() != 0) begin
            check("scoreboard_drained", 17'(sb_q.size()), 17'd0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
